// File: rtl/xor_reduce_accum_if.sv
// Stream bundle for xor_reduce_accum: beat input (I*) and frame-result output (O*).
// Both directions: a transfer happens on a rising CLK edge where valid && ready; valid never waits on ready.
interface xor_reduce_accum_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int CNTW  = 8
);
    logic [NCH*WIDTH-1:0] I;
    logic                 I_valid;
    logic                 I_last;
    logic                 I_ready;
    logic [WIDTH-1:0]     O;
    logic [CNTW-1:0]      O_beats;
    logic                 O_valid;
    logic                 O_ready;

    modport master (
        output I, I_valid, I_last, O_ready,
        input  I_ready, O, O_beats, O_valid
    );

    modport slave (
        input  I, I_valid, I_last, O_ready,
        output I_ready, O, O_beats, O_valid
    );
endinterface

// File: rtl/xor_reduce_accum.sv
// Streaming frame checksum: per-beat XOR reduction of NCH channels through a 4-ary tree,
// XOR-accumulated until I_last, then held as O/O_beats until the downstream handshake.
module xor_reduce_accum #(
    parameter int WIDTH     = 4,
    parameter int NCH       = 4,
    parameter int PIPELINED = 1,
    parameter int CNTW      = 8
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    xor_reduce_accum_if.slave      bus,
    output logic [1:0]             dbg_state
);

    function automatic int level_n(input int k);
        int n;
        n = NCH;
        for (int i = 0; i < k; i++) n = (n + 3) / 4;
        return n;
    endfunction

    function automatic int tree_depth(input int nch);
        int n;
        int l;
        n = nch;
        l = 0;
        while (n > 1) begin
            n = (n + 3) / 4;
            l++;
        end
        return l;
    endfunction

    localparam int L   = tree_depth(NCH);
    localparam int D   = (PIPELINED != 0) ? L : 0;
    localparam int DCW = 4;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic             live;
    logic [WIDTH-1:0] acc;
    logic [CNTW-1:0]  beats;
    logic [DCW-1:0]   drain_cnt;
    logic             o_valid;
    logic             i_ready;
    logic             accept;
    logic [WIDTH-1:0] tree_out;
    logic             tree_valid;

    // live holds I_ready low until the first edge after reset release.
    assign i_ready = live && (state == ACCUM);
    assign accept  = bus.I_valid && i_ready;

    if (L == 0) begin : g_bypass
        assign tree_out   = bus.I;
        assign tree_valid = accept;
    end else begin : g_tree
        for (genvar k = 0; k < L; k++) begin : lv
            localparam int NIN  = level_n(k);
            localparam int NOUT = level_n(k + 1);

            logic [NIN*WIDTH-1:0]  din;
            logic [NOUT*WIDTH-1:0] x;
            logic [NOUT*WIDTH-1:0] dout;
            logic                  vin;
            logic                  vout;

            if (k == 0) begin : g_src
                assign din = bus.I;
                assign vin = accept;
            end else begin : g_src
                assign din = lv[k-1].dout;
                assign vin = lv[k-1].vout;
            end

            // A trailing group with fewer than 4 members just XORs what it has.
            always_comb begin
                x = '0;
                for (int j = 0; j < NOUT; j++) begin
                    for (int g = 0; g < 4; g++) begin
                        if (4 * j + g < NIN) begin
                            x[j*WIDTH +: WIDTH] = x[j*WIDTH +: WIDTH] ^ din[(4*j+g)*WIDTH +: WIDTH];
                        end
                    end
                end
            end

            if (PIPELINED != 0) begin : g_reg
                always_ff @(posedge CLK or negedge ASYNCRESETN) begin
                    if (!ASYNCRESETN) begin
                        dout <= '0;
                        vout <= 1'b0;
                    end else begin
                        dout <= x;
                        vout <= vin;
                    end
                end
            end else begin : g_comb
                assign dout = x;
                assign vout = vin;
            end
        end

        assign tree_out   = lv[L-1].dout;
        assign tree_valid = lv[L-1].vout;
    end

    // DRAIN waits D cycles so the last beat reaches acc before HOLD; O_valid follows HOLD by one edge.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state     <= ACCUM;
            live      <= 1'b0;
            acc       <= '0;
            beats     <= '0;
            drain_cnt <= '0;
            o_valid   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (tree_valid) begin
                acc <= acc ^ tree_out;
                if (beats != '1) beats <= beats + 1'b1;
            end
            case (state)
                ACCUM: begin
                    if (accept && bus.I_last) begin
                        if (D > 0) begin
                            state     <= DRAIN;
                            drain_cnt <= DCW'(D);
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(1)) begin
                        state     <= HOLD;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (o_valid && bus.O_ready) begin
                        state   <= ACCUM;
                        o_valid <= 1'b0;
                        acc     <= '0;
                        beats   <= '0;
                    end else begin
                        o_valid <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.I_ready = i_ready;
    assign bus.O       = acc;
    assign bus.O_beats = beats;
    assign bus.O_valid = o_valid;
    assign dbg_state   = state;

endmodule

// File: tb/tb_xor_reduce_accum.sv
// Bench for xor_reduce_accum: five parameterisations sharing one stimulus path, selected by sel.
// Directed vector table, hand-written reset/saturation sequences and random frames vs an XOR model.
module tb_xor_reduce_accum;

  logic CLK = 1'b0;
  logic ASYNCRESETN;
  always #5 CLK = ~CLK;

  localparam int NDUT = 5;
  int cfg_nch  [NDUT] = '{4, 1, 5, 16, 4};
  int cfg_pip  [NDUT] = '{1, 1, 1, 0, 1};
  int cfg_cntw [NDUT] = '{8, 8, 8, 8, 2};

  logic [3:0]  chans [16];
  logic [63:0] in_flat;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  int          sel;

  logic [3:0]  fbuf [16][16];
  logic [11:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  always_comb begin
    in_flat = '0;
    for (int c = 0; c < 16; c++) in_flat[c*4 +: 4] = chans[c];
  end

  xor_reduce_accum_if #(.WIDTH(4), .NCH(4),  .CNTW(8)) if0 ();
  xor_reduce_accum_if #(.WIDTH(4), .NCH(1),  .CNTW(8)) if1 ();
  xor_reduce_accum_if #(.WIDTH(4), .NCH(5),  .CNTW(8)) if2 ();
  xor_reduce_accum_if #(.WIDTH(4), .NCH(16), .CNTW(8)) if3 ();
  xor_reduce_accum_if #(.WIDTH(4), .NCH(4),  .CNTW(2)) if4 ();

  logic [1:0] st0, st1, st2, st3, st4;

  assign if0.I = in_flat[15:0];
  assign if1.I = in_flat[3:0];
  assign if2.I = in_flat[19:0];
  assign if3.I = in_flat;
  assign if4.I = in_flat[15:0];
  assign if0.I_valid = in_valid && (sel == 0);
  assign if1.I_valid = in_valid && (sel == 1);
  assign if2.I_valid = in_valid && (sel == 2);
  assign if3.I_valid = in_valid && (sel == 3);
  assign if4.I_valid = in_valid && (sel == 4);
  assign if0.I_last = in_last;
  assign if1.I_last = in_last;
  assign if2.I_last = in_last;
  assign if3.I_last = in_last;
  assign if4.I_last = in_last;
  assign if0.O_ready = out_ready && (sel == 0);
  assign if1.O_ready = out_ready && (sel == 1);
  assign if2.O_ready = out_ready && (sel == 2);
  assign if3.O_ready = out_ready && (sel == 3);
  assign if4.O_ready = out_ready && (sel == 4);

  xor_reduce_accum #(.WIDTH(4), .NCH(4),  .PIPELINED(1), .CNTW(8)) u0 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(if0), .dbg_state(st0));
  xor_reduce_accum #(.WIDTH(4), .NCH(1),  .PIPELINED(1), .CNTW(8)) u1 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(if1), .dbg_state(st1));
  xor_reduce_accum #(.WIDTH(4), .NCH(5),  .PIPELINED(1), .CNTW(8)) u2 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(if2), .dbg_state(st2));
  xor_reduce_accum #(.WIDTH(4), .NCH(16), .PIPELINED(0), .CNTW(8)) u3 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(if3), .dbg_state(st3));
  xor_reduce_accum #(.WIDTH(4), .NCH(4),  .PIPELINED(1), .CNTW(2)) u4 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(if4), .dbg_state(st4));

  logic       cur_ready;
  logic       cur_ov;
  logic [3:0] cur_o;
  logic [7:0] cur_beats;

  always_comb begin
    cur_ready = 1'b0;
    cur_ov    = 1'b0;
    cur_o     = '0;
    cur_beats = '0;
    case (sel)
      0: begin cur_ready = if0.I_ready; cur_ov = if0.O_valid; cur_o = if0.O; cur_beats = if0.O_beats; end
      1: begin cur_ready = if1.I_ready; cur_ov = if1.O_valid; cur_o = if1.O; cur_beats = if1.O_beats; end
      2: begin cur_ready = if2.I_ready; cur_ov = if2.O_valid; cur_o = if2.O; cur_beats = if2.O_beats; end
      3: begin cur_ready = if3.I_ready; cur_ov = if3.O_valid; cur_o = if3.O; cur_beats = if3.O_beats; end
      4: begin cur_ready = if4.I_ready; cur_ov = if4.O_valid; cur_o = if4.O; cur_beats = if4.O_beats; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic fail_now(input string tag, input string name);
    checks++;
    errors++;
    $display("FAIL %s.%s: timed out waiting on DUT", tag, name);
  endtask

  // Reference model: latency from tree depth rules, checksum as plain XOR over every channel.
  function automatic int model_depth(input int k);
    int n;
    int l;
    n = cfg_nch[k];
    l = 0;
    while (n > 1) begin
      n = (n + 3) / 4;
      l++;
    end
    return (cfg_pip[k] != 0) ? l : 0;
  endfunction

  function automatic logic [3:0] model_sum(input int k, input int nb);
    logic [3:0] x;
    x = 4'h0;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < cfg_nch[k]; c++) x = x ^ fbuf[b][c];
    return x;
  endfunction

  function automatic int model_beats(input int k, input int nb);
    int mx;
    mx = (1 << cfg_cntw[k]) - 1;
    return (nb > mx) ? mx : nb;
  endfunction

  task automatic load_beat(input int k, input int b);
    for (int c = 0; c < 16; c++) chans[c] = (c < cfg_nch[k]) ? fbuf[b][c] : 4'h0;
  endtask

  task automatic run_frame(input int k, input int nb, input int hold, input logic [3:0] exp_o,
                           input int exp_beats, input int exp_lat, input string tag);
    int wait_cyc;
    int lat;
    bit ok;
    logic [11:0] exp;
    exp_q.push_back({exp_o, 8'(exp_beats)});
    sel = k;
    out_ready = 1'b0;
    for (int b = 0; b < nb; b++) begin
      load_beat(k, b);
      in_valid = 1'b1;
      in_last  = (b == nb - 1);
      wait_cyc = 0;
      while (!cur_ready && wait_cyc < 50) begin
        @(posedge CLK); #1;
        wait_cyc++;
      end
      if (!cur_ready) begin
        fail_now(tag, "accept");
        in_valid = 1'b0;
        in_last  = 1'b0;
        void'(exp_q.pop_front());
        return;
      end
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    lat = 0;
    ok  = 1'b1;
    while (!cur_ov && lat < 50) begin
      if (cur_ready) ok = 1'b0;
      @(posedge CLK); #1;
      lat++;
    end
    if (!cur_ov) begin
      fail_now(tag, "o_valid");
      void'(exp_q.pop_front());
      return;
    end
    check(tag, "latency", lat, exp_lat);
    check(tag, "ready_low_drain", ok, 1);

    ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (!cur_ov || cur_o !== exp_o || cur_beats !== 8'(exp_beats) || cur_ready) ok = 1'b0;
      @(posedge CLK); #1;
    end
    if (hold > 0) check(tag, "hold_stable", ok, 1);

    out_ready = 1'b1;
    exp = exp_q.pop_front();
    check(tag, "checksum", cur_o, exp[11:8]);
    check(tag, "beats", cur_beats, exp[7:0]);
    check(tag, "ready_low_hold", cur_ready, 0);
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check(tag, "valid_drop", cur_ov, 0);
    check(tag, "ready_back", cur_ready, 1);
  endtask

  typedef struct {
    int         k;
    int         nb;
    int         hold;
    logic [15:0] beat0;
    logic [15:0] beat1;
    logic [3:0] exp_o;
    int         exp_beats;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int hold;
    logic [15:0] w;

    vecs[0] = '{k: 0, nb: 1, hold: 0, beat0: 16'h8421, beat1: 16'h0000, exp_o: 4'hF, exp_beats: 1, exp_lat: 2};
    vecs[1] = '{k: 0, nb: 2, hold: 0, beat0: 16'h0053, beat1: 16'h000F, exp_o: 4'h9, exp_beats: 2, exp_lat: 2};
    vecs[2] = '{k: 0, nb: 2, hold: 5, beat0: 16'h0053, beat1: 16'h000F, exp_o: 4'h9, exp_beats: 2, exp_lat: 2};
    vecs[3] = '{k: 1, nb: 1, hold: 0, beat0: 16'h0007, beat1: 16'h0000, exp_o: 4'h7, exp_beats: 1, exp_lat: 1};
    vecs[4] = '{k: 3, nb: 2, hold: 1, beat0: 16'h1234, beat1: 16'h00F0, exp_o: 4'hB, exp_beats: 2, exp_lat: 1};
    vecs[5] = '{k: 2, nb: 1, hold: 2, beat0: 16'h0C30, beat1: 16'h0000, exp_o: 4'hF, exp_beats: 1, exp_lat: 3};

    // Clock/reset
    ASYNCRESETN = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    sel = 0;
    for (int c = 0; c < 16; c++) chans[c] = 4'h0;
    #1 ASYNCRESETN = 1'b0;
    #1;
    check("reset", "o", cur_o, 0);
    check("reset", "o_beats", cur_beats, 0);
    check("reset", "o_valid", cur_ov, 0);
    check("reset", "i_ready", cur_ready, 0);
    @(posedge CLK);
    @(posedge CLK); #2;
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    check("reset", "i_ready_release", cur_ready, 1);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 16; c++) fbuf[b][c] = 4'h0;
      for (int c = 0; c < 4; c++) begin
        w = vecs[i].beat0;
        fbuf[0][c] = w[c*4 +: 4];
        w = vecs[i].beat1;
        fbuf[1][c] = w[c*4 +: 4];
      end
      run_frame(vecs[i].k, vecs[i].nb, vecs[i].hold, vecs[i].exp_o,
                vecs[i].exp_beats, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Saturating beat counter
    for (int b = 0; b < 16; b++)
      for (int c = 0; c < 16; c++) fbuf[b][c] = 4'h1;
    run_frame(4, 6, 0, 4'h0, 3, 2, "saturate");

    // Reset mid-frame: two beats in flight are discarded
    sel = 0;
    fbuf[0][0] = 4'h1; fbuf[0][1] = 4'h2; fbuf[0][2] = 4'h4; fbuf[0][3] = 4'h0;
    fbuf[1][0] = 4'h3; fbuf[1][1] = 4'h0; fbuf[1][2] = 4'h0; fbuf[1][3] = 4'h0;
    for (int b = 0; b < 2; b++) begin
      load_beat(0, b);
      in_valid = 1'b1;
      in_last  = 1'b0;
      check("midreset", "ready_pre", cur_ready, 1);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("midreset", "o", cur_o, 0);
    check("midreset", "o_beats", cur_beats, 0);
    check("midreset", "o_valid", cur_ov, 0);
    check("midreset", "i_ready", cur_ready, 0);
    #2 ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    check("midreset", "i_ready_release", cur_ready, 1);
    fbuf[0][0] = 4'hA; fbuf[0][1] = 4'h0; fbuf[0][2] = 4'h0; fbuf[0][3] = 4'h0;
    run_frame(0, 1, 0, 4'hA, 1, 2, "post_reset");

    // Random frames on every configuration against the model
    for (int k = 0; k < NDUT; k++) begin
      for (int f = 0; f < 6; f++) begin
        nb   = $urandom_range(1, 8);
        hold = $urandom_range(0, 3);
        for (int b = 0; b < 16; b++)
          for (int c = 0; c < 16; c++) fbuf[b][c] = 4'($urandom_range(0, 15));
        run_frame(k, nb, hold, model_sum(k, nb), model_beats(k, nb), model_depth(k) + 1,
                  $sformatf("rand_k%0d_f%0d", k, f));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_reduce_accum.md
Name: xor_reduce_accum

Overview:
- Parametrised, streaming successor to the fixed 4x4 XOR array.
- Each accepted beat carries NCH channels of WIDTH bits.
- Channels are XOR-reduced per bit through a 4-input (SB_LUT4-sized) tree, optionally registered per level.
- The per-beat results are XOR-accumulated across a frame delimited by I_last.
- Emits one WIDTH-bit frame checksum plus a beat count over a valid/ready handshake.
- Sits between packet datapaths and integrity-check logic.

Parameters:
- WIDTH, 4, bits per channel (1..32).
- NCH, 4, channels per beat (1..64).
- PIPELINED, 1, 1 = register after every 4-input tree level; 0 = tree fully combinational.
- CNTW, 8, width of beat counter.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNCRESETN  in  1  asynchronous, active-low reset.
- I  in  NCH*WIDTH  beat data; channel c occupies bits [c*WIDTH +: WIDTH].
- I_valid  in  1  beat valid.
- I_last  in  1  final beat of frame; qualified by I_valid.
- I_ready  out  1  block accepts beat.
- O  out  WIDTH  frame checksum.
- O_beats  out  CNTW  beats in frame, saturating.
- O_valid  out  1  result valid.
- O_ready  in  1  downstream accepts result.

Behaviour:
- Tree depth:
  - L = ceil(log4(NCH)); L = 0 when NCH = 1.
  - Each level XORs groups of up to 4 values per bit; a partial group at the end of a level passes through (XOR of fewer inputs).
- Stage latency D:
  - D = L when PIPELINED = 1.
  - D = 0 when PIPELINED = 0 or NCH = 1.
- Beat acceptance: a beat is accepted on a rising edge where I_valid && I_ready.
- Tree valid tracking: a valid bit travels with data through the D stage registers. The tree never stalls; input is blocked upstream instead.
- Accumulator update: when the tree-output valid is high, acc <= acc ^ tree_out and beats <= beats + 1. beats saturates at 2^CNTW-1.
- FSM states: ACCUM, DRAIN, HOLD.
  - ACCUM:
    - I_ready = 1.
    - On an accepted beat with I_last = 1: go to DRAIN if D > 0, else go to HOLD.
  - DRAIN:
    - I_ready = 0.
    - A down-counter loaded with D decrements each cycle.
    - Go to HOLD on the edge where the last beat's contribution enters acc.
  - HOLD:
    - I_ready = 0, O_valid = 1, O = acc, O_beats = beats.
    - O and O_beats stay stable while O_ready = 0.
    - On O_valid && O_ready: clear acc and beats to 0, go to ACCUM.
- Latency: O_valid rises D+1 cycles after the edge accepting the last beat. D = 0 gives 1 cycle.
- Back-to-back frames:
  - The earliest next-frame beat is accepted in the cycle after the result handshake.
  - Sustained beat rate is 1 per cycle within a frame.
- Beats with I_last = 0 never produce output.
- O_valid is a registered output, asserted only in HOLD.
- I_ready is a combinational decode of state only; it never depends on I_valid.
- Reset (ASYNCRESETN low, any time including mid-frame or during HOLD):
  - State = ACCUM.
  - acc = 0, beats = 0, all tree stage registers and valids = 0, drain counter = 0.
  - O_valid = 0, O = 0, O_beats = 0, I_ready = 0 while asserted.
  - I_ready = 1 from the first cycle after release.
  - A partial frame in progress is discarded.
- Checksum equivalence: O equals the XOR over every channel of every accepted beat in the frame. This matches the cascaded-XOr4 reference model bit for bit.

Test Plan:
- Single beat, WIDTH=4, NCH=4, PIPELINED=1:
  - Stimulus: channels {0x1,0x2,0x4,0x8}, I_last=1, O_ready=1.
  - Required: O=0xF, O_beats=1, O_valid high for exactly 1 cycle, 2 cycles after acceptance (L=1).
- Two-beat frame, NCH=4:
  - Stimulus: {0x3,0x5,0x0,0x0} then {0xF,0x0,0x0,0x0} with I_last=1.
  - Required: O=0x9, O_beats=2, I_ready low from the edge after the last beat until the handshake.
- Backpressure:
  - Stimulus: same frame, O_ready low for 5 cycles.
  - Required: O=0x9 and O_valid stable for 5 cycles, I_ready=0 throughout, accept resumes the cycle after O_ready=1.
- Parameter sweep, random data vs XOR model, checking O and latency D+1:
  - NCH=1 (D=0): O=input, latency 1.
  - NCH=5, PIPELINED=1: L=2, latency 3.
  - NCH=16, PIPELINED=0: latency 1.
- Saturation, CNTW=2:
  - Stimulus: 6-beat frame of all 0x1 per channel, NCH=4.
  - Required: O_beats=3, O=0x0.
- Reset mid-frame:
  - Stimulus: 2 beats accepted, ASYNCRESETN pulsed low between clock edges, then a 1-beat frame {0xA,0,0,0}.
  - Required: outputs 0 immediately on reset; result O=0xA, O_beats=1 (no contamination from the discarded beats).
